// File: rtl/bin2bcd_converter.sv
// ---------------------------------------------------------------------------
// bin2bcd_converter
//   Sequential double-dabble binary-to-BCD converter. One input bit is
//   consumed per clock; a conversion takes BIN_W+2 cycles from accepted start
//   to ready again. The result is packed BCD, one nibble per downstream 7-seg
//   digit decoder, with digit 0 (units) in bcd_out[3:0].
//
// Parameters
//   BIN_W     width of the unsigned binary input
//   DIGITS    number of BCD output nibbles
//
// Ports
//   clk       system clock, rising edge
//   reset     synchronous, active-high reset
//   start     conversion request, accepted only while ready=1
//   bin_in    value to convert, captured on the accepting edge
//   ready     1 while idle
//   busy      1 while a conversion is in flight (~ready)
//   done      single-cycle pulse; bcd_out/overflow are valid in that cycle
//   bcd_out   packed BCD result, held between conversions
//   overflow  1 when the last value exceeded 10^DIGITS-1 (bcd_out = all 9s)
//
// Build option
//   LEADING_ZERO_BLANK_EN  when defined, leading zero nibbles above digit 0
//                          are replaced with 4'hF (blank digit) on a normal
//                          (non-overflow) result.
// ---------------------------------------------------------------------------
module bin2bcd_converter #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [BIN_W-1:0]   shreg_reg;
  logic [BCD_W-1:0]   scratch_reg;
  logic               ovf_reg;
  logic [CNT_W-1:0]   cnt_reg;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   scratch_shift;
  logic [BIN_W-1:0]   shreg_shift;
  logic               ovf_shift;
  logic               last_shift;
  logic [BCD_W-1:0]   shown;
  logic [BCD_W-1:0]   result;

  // Add-3 correction per nibble; nibbles are independent (no carry between).
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5) ?
                              scratch_reg[4*gi +: 4] + 4'd3 :
                              scratch_reg[4*gi +: 4];
    end
  endgenerate

  // One shift step of {scratch, shreg}; the bit leaving the top nibble can
  // only be set when the value does not fit in DIGITS decimal digits.
  assign scratch_shift = {adj[BCD_W-2:0], shreg_reg[BIN_W-1]};
  assign shreg_shift   = {shreg_reg[BIN_W-2:0], 1'b0};
  assign ovf_shift     = ovf_reg | adj[BCD_W-1];
  assign last_shift    = (cnt_reg == CNT_W'(1));

`ifdef LEADING_ZERO_BLANK_EN
  // upper_zero[i] is 1 when nibble i and every nibble above it are zero.
  logic [DIGITS:0] upper_zero;
  assign upper_zero[DIGITS] = 1'b1;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_blank
      assign upper_zero[gi] = upper_zero[gi+1] & (scratch_shift[4*gi +: 4] == 4'd0);
      if (gi == 0) begin : g_units
        // Units digit is always shown so a zero result still displays "0".
        assign shown[3:0] = scratch_shift[3:0];
      end else begin : g_upper
        assign shown[4*gi +: 4] = upper_zero[gi] ? 4'hF : scratch_shift[4*gi +: 4];
      end
    end
  endgenerate
`else
  assign shown = scratch_shift;
`endif

  // Overflow overrides blanking: show all 9s.
  assign result = ovf_shift ? {DIGITS{4'h9}} : shown;

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = SHIFT;
      end
      SHIFT: begin
        if (last_shift) state_next = FINISH;
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    busy = ~ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      shreg_reg   <= '0;
      scratch_reg <= '0;
      ovf_reg     <= 1'b0;
      cnt_reg     <= '0;
      bcd_out     <= '0;
      overflow    <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            shreg_reg   <= bin_in;
            scratch_reg <= '0;
            ovf_reg     <= 1'b0;
            cnt_reg     <= CNT_W'(BIN_W);
          end
        end
        SHIFT: begin
          shreg_reg   <= shreg_shift;
          scratch_reg <= scratch_shift;
          ovf_reg     <= ovf_shift;
          cnt_reg     <= cnt_reg - CNT_W'(1);
          // Result is registered on the edge entering FINISH so that it is
          // already valid in the cycle where done is high.
          if (last_shift) begin
            bcd_out  <= result;
            overflow <= ovf_shift;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_converter.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_converter
//   Self-checking bench for bin2bcd_converter. Two instances: the default
//   16-bit / 5-digit build and a 10-bit / 3-digit build that can overflow.
//   Expected BCD is computed from decimal arithmetic (mod/div by 10).
// ---------------------------------------------------------------------------
module tb_bin2bcd_converter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        start = 1'b0;
  logic [15:0] bin_in = '0;
  logic        ready, busy, done, overflow;
  logic [19:0] bcd_out;

  logic        s_start = 1'b0;
  logic [9:0]  s_bin = '0;
  logic        s_ready, s_busy, s_done, s_overflow;
  logic [11:0] s_bcd;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  bin2bcd_converter #(.BIN_W(16), .DIGITS(5)) u_dut (
    .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
    .ready(ready), .busy(busy), .done(done), .bcd_out(bcd_out),
    .overflow(overflow)
  );

  bin2bcd_converter #(.BIN_W(10), .DIGITS(3)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .bin_in(s_bin),
    .ready(s_ready), .busy(s_busy), .done(s_done), .bcd_out(s_bcd),
    .overflow(s_overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Decimal reference: digits by repeated division, saturate to all 9s.
  function automatic logic [31:0] model_bcd(input int v, input int d, output bit ovf);
    logic [31:0] r;
    int x;
    int lim;
    lim = 1;
    for (int i = 0; i < d; i++) lim *= 10;
    r = '0;
    ovf = (v >= lim);
    if (ovf) begin
      for (int i = 0; i < d; i++) r[4*i +: 4] = 4'h9;
    end else begin
      x = v;
      for (int i = 0; i < d; i++) begin
        r[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
`ifdef LEADING_ZERO_BLANK_EN
      begin
        bit lead;
        lead = 1'b1;
        for (int i = d - 1; i > 0; i--) begin
          if (lead && r[4*i +: 4] == 4'h0) r[4*i +: 4] = 4'hF;
          else lead = 1'b0;
        end
      end
`endif
    end
    return r;
  endfunction

  function automatic logic cur_ready(input bit sm);
    return sm ? s_ready : ready;
  endfunction

  function automatic logic cur_done(input bit sm);
    return sm ? s_done : done;
  endfunction

  task automatic set_in(input bit sm, input logic st, input int v);
    if (sm) begin
      s_start = st;
      s_bin   = 10'(v);
    end else begin
      start  = st;
      bin_in = 16'(v);
    end
  endtask

  // One conversion with random start/bin_in noise while busy.
  task automatic convert(input bit sm, input int v);
    int edges;
    int w;
    int d;
    bit eo;
    logic [31:0] exp;
    w = sm ? 10 : 16;
    d = sm ? 3 : 5;
    exp = model_bcd(v, d, eo);
    edges = 0;
    while (!cur_ready(sm) && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check("ready_wait", 32'(cur_ready(sm)), 32'd1);
    set_in(sm, 1'b1, v);
    @(posedge clk); #1;
    edges = 0;
    while (edges < 40) begin
      set_in(sm, 1'($urandom_range(0, 1)), int'($urandom));
      @(posedge clk); #1;
      edges++;
      if (cur_done(sm)) break;
    end
    set_in(sm, 1'b0, 0);
    check("latency", 32'(edges), 32'(w));
    if (sm) begin
      check("s_bcd", 32'(s_bcd), exp);
      check("s_ovf", 32'(s_overflow), 32'(eo));
    end else begin
      check("bcd", 32'(bcd_out), exp);
      check("ovf", 32'(overflow), 32'(eo));
    end
    $display("conv %s in=%0d bcd=%h ovf=%0d exp=%h", sm ? "small" : "main", v,
             sm ? 32'(s_bcd) : 32'(bcd_out), sm ? s_overflow : overflow, exp);
    @(posedge clk); #1;
    check("done_single", 32'(cur_done(sm)), 32'd0);
    check("ready_back", 32'(cur_ready(sm)), 32'd1);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (done && ready) check("done_ready_excl", 32'(done & ready), 32'd0);
      if (busy == ready) check("busy_inv", 32'(busy), 32'(~ready));
    end
  end

  initial begin
    int q[$];
    int last_done;
    int n_done;
    int exp_v;
    bit eo;
    logic [31:0] exp;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;

    // Directed corner values, then random.
    convert(0, 0);
    convert(0, 65535);
    convert(0, 1234);
    convert(0, 42);
    convert(0, 10000);
    convert(0, 9);
    for (int i = 0; i < 12; i++) convert(0, int'($urandom_range(0, 65535)));

    convert(1, 1000);
    convert(1, 999);
    convert(1, 1023);
    convert(1, 0);
    for (int i = 0; i < 8; i++) convert(1, int'($urandom_range(0, 1023)));

    // start held high: back-to-back conversions, one per 18 cycles.
    last_done = -1;
    n_done = 0;
    start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      bin_in = 16'($urandom);
      if (ready) q.push_back(int'(bin_in));
      @(posedge clk); #1;
      if (done) begin
        exp_v = (q.size() > 0) ? q.pop_front() : -1;
        exp = model_bcd(exp_v, 5, eo);
        check("b2b_bcd", 32'(bcd_out), exp);
        $display("b2b in=%0d bcd=%h exp=%h", exp_v, bcd_out, exp);
        if (last_done >= 0) check("b2b_period", 32'(i - last_done), 32'd18);
        last_done = i;
        n_done++;
      end
    end
    start = 1'b0;
    q.delete();
    check("b2b_count", 32'(n_done), 32'd3);

    // Reset five cycles into a conversion aborts it.
    convert(0, 777);
    start = 1'b1;
    bin_in = 16'd54321;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bcd", 32'(bcd_out), 32'd0);
    check("abort_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    n_done = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    convert(0, 4321);
    convert(0, 65535);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
